tm1638_frame_writer: RTL and testbench
======================================

Name: tm1638_frame_writer

Overview:
- Upstream producer for spi_fifo in the TM1638 display path.
- On request, snapshots one display frame: 8 digit segment bytes, 8 LEDs, brightness and on/off.
- Serialises the frame into the 19-word TM1638 command sequence.
- Pushes the words into the SPI FIFO through its valid/full interface.

Parameters:
- NUM_DIGITS, 8, digit/LED positions written per frame. Fixed at 8 for TM1638; any other value is a compile-time error.

Ports:
- i_Clk  input  1  system clock; all logic on posedge.
- i_Rst_n  input  1  reset, asynchronous and active-low.
- i_Update  input  1  one-cycle request to write a new frame.
- i_Seg  input  64  segment bytes; digit k = i_Seg[8k+7:8k].
- i_Leds  input  8  LED k = i_Leds[k].
- i_Brightness  input  3  pulse-width setting 0..7.
- i_Display_On  input  1  display enable.
- o_Busy  output  1  frame in progress or pending.
- o_Done  output  1  one-cycle pulse after the last word is accepted.
- i_FIFO_Full  input  1  full flag from spi_fifo.
- o_Data_Valid  output  1  push strobe to spi_fifo.
- o_Data  output  17  word to spi_fifo.

Behaviour:
- Word format:
  - [7:0] byte, sent LSB-first by SPI.
  - [15:8] always 0.
  - [16] CONT: 1 = STB held low into the next word (same transaction), 0 = STB released after this byte.
- Reset: asynchronous assert while i_Rst_n=0. State=IDLE, snapshot regs=0, pending=0, o_Busy=0, o_Done=0, o_Data_Valid=0, o_Data=0. Deassertion is synchronised by the instantiating top.
- States:
  - IDLE -> CMD_DATA -> CMD_ADDR -> PAYLOAD -> CMD_CTRL -> IDLE.
- IDLE:
  - i_Update=1 latches i_Seg/i_Leds/i_Brightness/i_Display_On into the snapshot, clears payload index, enters CMD_DATA next cycle.
- Words emitted per frame (19 total):
  - CMD_DATA: 0x00040 (auto-increment write, CONT=0).
  - CMD_ADDR: 0x100C0 (address 0, CONT=1).
  - PAYLOAD: index i=0..15.
    - Even i=2k: byte = seg[k].
    - Odd i=2k+1: byte = {7'b0, led[k]}.
    - CONT=1 for i<15, CONT=0 for i=15.
  - CMD_CTRL: {9'b0, 1'b1, 3'b000, i_Display_On_snap, i_Brightness_snap}, i.e. 0x80|on<<3|bright, CONT=0.
- Handshake:
  - In every emitting state, o_Data_Valid = ~i_FIFO_Full (combinational). o_Data is decoded combinationally from state, index and snapshot.
  - A word is accepted on the posedge where o_Data_Valid=1. The state or index advances only on acceptance.
  - Full stalls indefinitely with o_Data held stable. No word is dropped or duplicated.
  - o_Data_Valid=0 in IDLE. Maximum throughput is one word per cycle.
- Latency: i_Update at edge N gives the first word valid in cycle N+1. A never-full FIFO completes the frame in 19 cycles. o_Done pulses the cycle after CMD_CTRL is accepted.
- o_Busy=1 from the cycle after i_Update until IDLE is re-entered with pending=0.
- i_Update while not IDLE:
  - Sets pending and overwrites the snapshot-next registers (last request wins).
  - The active frame keeps its original snapshot.
  - On CMD_CTRL acceptance with pending=1: load the pending values, clear pending, go directly to CMD_DATA (no IDLE cycle), still pulse o_Done.
- i_Update in the same cycle as CMD_CTRL acceptance counts as pending.
- Index counter is 4 bits and never wraps: the transition out of PAYLOAD occurs at i=15.
- Reset mid-frame abandons the frame immediately. A half-written transaction in spi_fifo is that module's reset responsibility; the same reset drives both blocks.

Test Plan:
- Reset then idle: i_Rst_n=0 for 3 clocks -> all outputs 0. With no i_Update for 20 cycles -> o_Data_Valid never 1, o_Busy=0.
- Single frame, FIFO never full: i_Seg=64'h0706050403020100, i_Leds=8'hA5, bright=5, on=1.
  - Words: 0x00040, 0x100C0, then 0x10000, 0x10001, 0x10001, 0x10000, 0x10002, 0x10001, 0x10003, 0x10000, ..., 0x10007, then 0x00001 (led7=1, CONT=0 on i=15), then 0x0008D.
  - 19 consecutive valids; o_Done one cycle after.
- Backpressure: hold i_FIFO_Full=1 for 5 cycles during PAYLOAD i=6 -> o_Data_Valid=0 for those 5 cycles. i=6 word is emitted exactly once after release; total accepted count=19.
- Update during frame: second i_Update (seg all 0xFF, leds 0, bright 0, on 0) at word 4 -> first frame completes unchanged. Second frame starts the cycle after the first 0x0008x word, payload 0xFF/0x00, ctrl 0x00080. o_Busy continuous; two o_Done pulses.
- Reset mid-frame: i_Rst_n=0 at PAYLOAD i=9 -> o_Data_Valid falls asynchronously, state IDLE. After release, no words until a new i_Update, which then starts at 0x00040.
- Coincident update: i_Update on the CMD_CTRL acceptance edge -> a second full 19-word frame follows with no gap.

Source files
------------

// File: rtl/tm1638_frame_writer.sv
// tm1638_frame_writer
// Snapshots one TM1638 display frame (8 segment bytes, 8 LEDs, brightness,
// on/off) and serialises it into the 19-word command sequence consumed by
// spi_fifo. Word layout: [7:0] byte (LSB-first on the wire), [15:8] zero,
// [16] CONT (1 = keep STB low into the next word).
module tm1638_frame_writer #(
  parameter int NUM_DIGITS = 8
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Update,
  input  logic [63:0] i_Seg,
  input  logic [7:0]  i_Leds,
  input  logic [2:0]  i_Brightness,
  input  logic        i_Display_On,
  output logic        o_Busy,
  output logic        o_Done,
  input  logic        i_FIFO_Full,
  output logic        o_Data_Valid,
  output logic [16:0] o_Data
);

  // The TM1638 has exactly eight grid positions; the word sequence below
  // (16 payload words, 4-bit index) is built around that.
  if (NUM_DIGITS != 8) begin : g_num_digits_check
    $error("tm1638_frame_writer: NUM_DIGITS must be 8");
  end

  // Fixed command bytes with their CONT flag in bit 16.
  localparam logic [16:0] WORD_CMD_DATA = 17'h00040; // data cmd: write, auto-increment
  localparam logic [16:0] WORD_CMD_ADDR = 17'h100C0; // address 0, payload follows in same STB
  localparam logic [3:0]  IDX_LAST      = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD_DATA = 3'd1,
    ST_CMD_ADDR = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_CMD_CTRL = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  idx_r;
  logic [3:0]  idx_nx_s;
  logic        done_r;
  logic        done_nx_s;

  // Snapshot used by the frame currently being written.
  logic [63:0] seg_snap_r;
  logic [7:0]  leds_snap_r;
  logic [2:0]  bright_snap_r;
  logic        on_snap_r;

  // Most recent request received while a frame was in flight.
  logic        pend_r;
  logic [63:0] seg_pend_r;
  logic [7:0]  leds_pend_r;
  logic [2:0]  bright_pend_r;
  logic        on_pend_r;

  // Source for the next snapshot load: a request in this very cycle is the
  // newest one, otherwise the pending copy.
  logic [63:0] seg_src_s;
  logic [7:0]  leds_src_s;
  logic [2:0]  bright_src_s;
  logic        on_src_s;

  logic        snap_ld_s;
  logic        valid_s;
  logic        accept_s;
  logic [16:0] data_s;
  logic [7:0]  byte_s;
  logic        cont_s;

  // Select where a snapshot load takes its values from.
  always_comb begin
    if (i_Update) begin
      seg_src_s    = i_Seg;
      leds_src_s   = i_Leds;
      bright_src_s = i_Brightness;
      on_src_s     = i_Display_On;
    end else begin
      seg_src_s    = seg_pend_r;
      leds_src_s   = leds_pend_r;
      bright_src_s = bright_pend_r;
      on_src_s     = on_pend_r;
    end
  end

  // Decode the outgoing word and push strobe from state, index and snapshot.
  always_comb begin
    data_s  = 17'h00000;
    valid_s = 1'b0;
    byte_s  = 8'h00;
    cont_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        data_s  = 17'h00000;
        valid_s = 1'b0;
      end
      ST_CMD_DATA: begin
        data_s  = WORD_CMD_DATA;
        valid_s = ~i_FIFO_Full;
      end
      ST_CMD_ADDR: begin
        data_s  = WORD_CMD_ADDR;
        valid_s = ~i_FIFO_Full;
      end
      ST_PAYLOAD: begin
        // Even index carries digit k's segments, odd index carries LED k.
        if (idx_r[0] == 1'b0) begin
          byte_s = seg_snap_r[{idx_r[3:1], 3'b000} +: 8];
        end else begin
          byte_s = {7'b000_0000, leds_snap_r[idx_r[3:1]]};
        end
        // STB is released only after the last LED byte.
        if (idx_r == IDX_LAST) begin
          cont_s = 1'b0;
        end else begin
          cont_s = 1'b1;
        end
        data_s  = {cont_s, 8'h00, byte_s};
        valid_s = ~i_FIFO_Full;
      end
      ST_CMD_CTRL: begin
        data_s  = {9'h000, 1'b1, 3'b000, on_snap_r, bright_snap_r};
        valid_s = ~i_FIFO_Full;
      end
      default: begin
        data_s  = 17'h00000;
        valid_s = 1'b0;
      end
    endcase
  end

  assign accept_s     = valid_s;
  assign o_Data_Valid = valid_s;
  assign o_Data       = data_s;
  assign o_Done       = done_r;
  assign o_Busy       = (state_r != ST_IDLE);

  // Next-state logic: advance only when the current word is accepted.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    done_nx_s  = 1'b0;
    snap_ld_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_Update) begin
          state_nx_s = ST_CMD_DATA;
          idx_nx_s   = 4'd0;
          snap_ld_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CMD_DATA: begin
        if (accept_s) begin
          state_nx_s = ST_CMD_ADDR;
        end else begin
          state_nx_s = ST_CMD_DATA;
        end
      end
      ST_CMD_ADDR: begin
        if (accept_s) begin
          state_nx_s = ST_PAYLOAD;
          idx_nx_s   = 4'd0;
        end else begin
          state_nx_s = ST_CMD_ADDR;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          if (idx_r == IDX_LAST) begin
            state_nx_s = ST_CMD_CTRL;
          end else begin
            idx_nx_s = idx_r + 4'd1;
          end
        end else begin
          state_nx_s = ST_PAYLOAD;
        end
      end
      ST_CMD_CTRL: begin
        if (accept_s) begin
          done_nx_s = 1'b1;
          // A queued (or simultaneous) request chains straight into the
          // next frame without passing through IDLE.
          if (pend_r || i_Update) begin
            state_nx_s = ST_CMD_DATA;
            idx_nx_s   = 4'd0;
            snap_ld_s  = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_CMD_CTRL;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        idx_nx_s   = 4'd0;
      end
    endcase
  end

  // State, payload index and done pulse registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      done_r  <= done_nx_s;
    end
  end

  // Active-frame snapshot, reloaded only when a frame starts.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      seg_snap_r    <= 64'h0;
      leds_snap_r   <= 8'h00;
      bright_snap_r <= 3'd0;
      on_snap_r     <= 1'b0;
    end else if (snap_ld_s) begin
      seg_snap_r    <= seg_src_s;
      leds_snap_r   <= leds_src_s;
      bright_snap_r <= bright_src_s;
      on_snap_r     <= on_src_s;
    end
  end

  // Pending request: newest request wins, consumed when a frame starts.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pend_r        <= 1'b0;
      seg_pend_r    <= 64'h0;
      leds_pend_r   <= 8'h00;
      bright_pend_r <= 3'd0;
      on_pend_r     <= 1'b0;
    end else begin
      if (snap_ld_s) begin
        pend_r <= 1'b0;
      end else if (i_Update) begin
        pend_r <= 1'b1;
      end
      if (i_Update) begin
        seg_pend_r    <= i_Seg;
        leds_pend_r   <= i_Leds;
        bright_pend_r <= i_Brightness;
        on_pend_r     <= i_Display_On;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_frame_writer.sv
// Directed testbench for tm1638_frame_writer.
module tb_tm1638_frame_writer;

  logic        clk;
  logic        rst_n;
  logic        upd;
  logic [63:0] seg;
  logic [7:0]  leds;
  logic [2:0]  br;
  logic        on;
  logic        busy;
  logic        done;
  logic        full;
  logic        valid;
  logic [16:0] data;

  int checks;
  int failures;
  logic [16:0] last_words [19];

  tm1638_frame_writer #(.NUM_DIGITS(8)) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Update     (upd),
    .i_Seg        (seg),
    .i_Leds       (leds),
    .i_Brightness (br),
    .i_Display_On (on),
    .o_Busy       (busy),
    .o_Done       (done),
    .i_FIFO_Full  (full),
    .o_Data_Valid (valid),
    .o_Data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected word n (0..18) of a frame built from the given values.
  function automatic logic [16:0] exp_word(input int n, input logic [63:0] s,
                                           input logic [7:0] l, input logic [2:0] b,
                                           input logic o);
    logic [7:0] byt;
    int i;
    if (n == 0) return 17'h00040;
    if (n == 1) return 17'h100C0;
    if (n == 18) return {9'h000, 1'b1, 3'b000, o, b};
    i = n - 2;
    if (i % 2 == 0) byt = s[(i / 2) * 8 +: 8];
    else            byt = {7'b000_0000, l[i / 2]};
    return {(i != 15) ? 1'b1 : 1'b0, 8'h00, byt};
  endfunction

  // Present a one-cycle update request at the next posedge.
  task automatic start(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b, input logic o);
    @(negedge clk);
    seg = s; leds = l; br = b; on = o; upd = 1'b1; full = 1'b0;
  endtask

  // Consume and check one 19-word frame. Optional stall before word stall_at,
  // optional new request presented alongside word upd_at.
  task automatic run_frame(input logic [63:0] s, input logic [7:0] l, input logic [2:0] b,
                           input logic o, input int stall_at, input int stall_len,
                           input int upd_at, input logic [63:0] us, input logic [7:0] ul,
                           input logic [2:0] ub, input logic uo, input logic chk_done0);
    int w;
    int stalled;
    int accepted;
    logic busy_ok;
    w = 0; stalled = 0; accepted = 0; busy_ok = 1'b1;
    while (w < 19) begin
      @(negedge clk);
      upd = 1'b0;
      if (w == stall_at && stalled < stall_len) begin
        full = 1'b1;
        #1;
        check1("stall_valid", valid, 1'b0);
        check("stall_data_stable", data, exp_word(w, s, l, b, o));
        if (valid) accepted++;
        stalled++;
      end else begin
        full = 1'b0;
        if (w == upd_at) begin
          seg = us; leds = ul; br = ub; on = uo; upd = 1'b1;
        end
        #1;
        if (w == 0 && chk_done0) check1("done_chained", done, 1'b1);
        check1("word_valid", valid, 1'b1);
        check("word_data", data, exp_word(w, s, l, b, o));
        last_words[w] = data;
        if (valid) accepted++;
        w++;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check("accepted_count", 17'(accepted), 17'd19);
    check1("busy_during_frame", busy_ok, 1'b1);
  endtask

  // After the final frame: one done pulse with busy already low, then quiet.
  task automatic end_frame();
    @(negedge clk);
    upd = 1'b0;
    #1;
    check1("done_pulse", done, 1'b1);
    check1("busy_after", busy, 1'b0);
    check1("valid_after", valid, 1'b0);
    @(negedge clk);
    #1;
    check1("done_single", done, 1'b0);
  endtask

  initial begin
    logic seen;
    checks = 0; failures = 0;
    rst_n = 1'b0; upd = 1'b0; seg = 64'h0; leds = 8'h00; br = 3'd0; on = 1'b0; full = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_valid", valid, 1'b0);
    check("rst_data", data, 17'h00000);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    check1("idle_quiet", seen, 1'b0);

    // Single frame, FIFO never full
    start(64'h0706050403020100, 8'hA5, 3'd5, 1'b1);
    run_frame(64'h0706050403020100, 8'hA5, 3'd5, 1'b1, -1, 0, -1, 64'h0, 8'h00, 3'd0, 1'b0, 1'b0);
    check("hand_w2", last_words[2], 17'h10000);
    check("hand_w3", last_words[3], 17'h10001);
    check("hand_w5", last_words[5], 17'h10000);
    check("hand_w16", last_words[16], 17'h10007);
    check("hand_w17", last_words[17], 17'h00001);
    check("hand_ctrl", last_words[18], 17'h0008D);
    end_frame();

    // Backpressure for 5 cycles at payload index 6 (word 8)
    start(64'h0123456789ABCDEF, 8'h3C, 3'd2, 1'b1);
    run_frame(64'h0123456789ABCDEF, 8'h3C, 3'd2, 1'b1, 8, 5, -1, 64'h0, 8'h00, 3'd0, 1'b0, 1'b0);
    check("hand_bp_w8", last_words[8], 17'h10089);
    check("hand_bp_ctrl", last_words[18], 17'h0008A);
    end_frame();

    // Update during frame at word 4
    start(64'h1122334455667788, 8'h81, 3'd7, 1'b1);
    run_frame(64'h1122334455667788, 8'h81, 3'd7, 1'b1, -1, 0, 4,
              64'hFFFFFFFFFFFFFFFF, 8'h00, 3'd0, 1'b0, 1'b0);
    check("hand_upd_ctrl1", last_words[18], 17'h0008F);
    run_frame(64'hFFFFFFFFFFFFFFFF, 8'h00, 3'd0, 1'b0, -1, 0, -1, 64'h0, 8'h00, 3'd0, 1'b0, 1'b1);
    check("hand_upd_seg", last_words[2], 17'h100FF);
    check("hand_upd_led", last_words[3], 17'h10000);
    check("hand_upd_ctrl2", last_words[18], 17'h00080);
    end_frame();

    // Reset mid-frame at payload index 9 (word 11)
    start(64'hDEADBEEFCAFEF00D, 8'h10, 3'd3, 1'b1);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      upd = 1'b0;
    end
    @(negedge clk);
    #1;
    check("mid_word9", data, 17'h10001);
    rst_n = 1'b0;
    #1;
    check1("mid_rst_valid", valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", data, 17'h00000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    check1("no_words_after_reset", seen, 1'b0);
    start(64'h0F0E0D0C0B0A0908, 8'hFF, 3'd1, 1'b0);
    run_frame(64'h0F0E0D0C0B0A0908, 8'hFF, 3'd1, 1'b0, -1, 0, -1, 64'h0, 8'h00, 3'd0, 1'b0, 1'b0);
    check("hand_restart_w0", last_words[0], 17'h00040);
    end_frame();

    // Coincident update on the control-word acceptance edge
    start(64'h8877665544332211, 8'h0F, 3'd4, 1'b1);
    run_frame(64'h8877665544332211, 8'h0F, 3'd4, 1'b1, -1, 0, 18,
              64'h00000000000000AA, 8'h01, 3'd6, 1'b1, 1'b0);
    run_frame(64'h00000000000000AA, 8'h01, 3'd6, 1'b1, -1, 0, -1, 64'h0, 8'h00, 3'd0, 1'b0, 1'b1);
    check("hand_coinc_w2", last_words[2], 17'h100AA);
    check("hand_coinc_ctrl", last_words[18], 17'h0008E);
    end_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
